// File: rtl/gpu_line_raster.sv
// rtl/gpu_line_raster.sv - Bresenham line rasteriser, all octants, stallable pixel stream; optional clip via GPU_LINE_CLIP_EN
module gpu_line_raster #(
    parameter int          X_BITS     = 10,
    parameter int          Y_BITS     = 9,
    parameter int          COLOR_BITS = 24,
    parameter int unsigned FB_WIDTH   = 640,
    parameter int unsigned FB_HEIGHT  = 480
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_BITS-1:0]     cmd_x1,
    input  logic [Y_BITS-1:0]     cmd_y1,
    input  logic [X_BITS-1:0]     cmd_x2,
    input  logic [Y_BITS-1:0]     cmd_y2,
    input  logic [COLOR_BITS-1:0] cmd_color,
    input  logic                  abort,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     pix_y,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
);

    localparam int W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;

`ifdef GPU_LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP} state_t;

    state_t state, state_n;

    logic [X_BITS-1:0]   x2_q;
    logic [Y_BITS-1:0]   y2_q;
    logic signed [W-1:0] dx_q, dy_q, err_q;
    logic                sx_neg, sy_neg;
    logic                done_q;

    logic signed [W-1:0] cur_xs, cur_ys, end_xs, end_ys;
    logic signed [W-1:0] diff_x, diff_y, abs_dx, abs_dy, err_n;
    logic signed [W:0]   e2, dx_e, dy_e;
    logic                step_x, step_y;
    logic                visible, at_end, adv, fin;

    // Setup arithmetic works on the latched start point (held in pix_x/pix_y) and end point.
    assign cur_xs = signed'(W'(pix_x));
    assign cur_ys = signed'(W'(pix_y));
    assign end_xs = signed'(W'(x2_q));
    assign end_ys = signed'(W'(y2_q));
    assign diff_x = end_xs - cur_xs;
    assign diff_y = end_ys - cur_ys;
    assign abs_dx = diff_x[W-1] ? -diff_x : diff_x;
    assign abs_dy = diff_y[W-1] ? -diff_y : diff_y;

    // Error term doubled one bit wider so 2*err never wraps.
    assign e2     = {err_q, 1'b0};
    assign dx_e   = {dx_q[W-1], dx_q};
    assign dy_e   = {dy_q[W-1], dy_q};
    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);
    assign err_n  = err_q + (step_x ? dy_q : W'(0)) + (step_y ? dx_q : W'(0));

    // Off-screen steps are silently consumed at one per cycle when clipping is built in.
    assign visible = !CLIP_EN || ((32'(pix_x) < FB_WIDTH) && (32'(pix_y) < FB_HEIGHT));
    assign at_end  = (pix_x == x2_q) && (pix_y == y2_q);
    assign adv     = (state == S_STEP) && (visible ? pix_ready : 1'b1);
    assign fin     = adv && at_end;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign pix_valid = (state == S_STEP) && visible;
    assign pix_last  = (state == S_STEP) && visible && at_end;
    assign done      = done_q;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state: a completing handshake wins over a simultaneous abort.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) state_n = S_SETUP;
            S_SETUP: state_n = abort ? S_IDLE : S_STEP;
            S_STEP:  if (fin || abort) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command latch, per-line setup and Bresenham stepping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fin;
            if (state == S_IDLE && cmd_valid) begin
                pix_x     <= cmd_x1;
                pix_y     <= cmd_y1;
                x2_q      <= cmd_x2;
                y2_q      <= cmd_y2;
                pix_color <= cmd_color;
            end
            if (state == S_SETUP) begin
                dx_q   <= abs_dx;
                dy_q   <= -abs_dy;
                err_q  <= abs_dx - abs_dy;
                sx_neg <= !(pix_x < x2_q);
                sy_neg <= !(pix_y < y2_q);
            end
            if (adv && !at_end) begin
                err_q <= err_n;
                if (step_x) pix_x <= sx_neg ? pix_x - 1'b1 : pix_x + 1'b1;
                if (step_y) pix_y <= sy_neg ? pix_y - 1'b1 : pix_y + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpu_line_raster.sv
// tb/tb_gpu_line_raster.sv - self-checking bench for gpu_line_raster against a behavioural line model
module tb_gpu_line_raster;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x1 = '0, cmd_x2 = '0;
    logic [8:0]  cmd_y1 = '0, cmd_y2 = '0;
    logic [23:0] cmd_color = '0;
    logic        abort = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [23:0] pix_color;
    logic        pix_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int qx[$];
    int qy[$];
    bit ql[$];
    bit m_start_vis, m_end_vis;
    int m_x1, m_y1, m_x2, m_y2;
    logic [23:0] m_color;

    gpu_line_raster dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
        .cmd_color(cmd_color), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit on_screen(int x, int y);
`ifdef GPU_LINE_CLIP_EN
        return (x < 640) && (y < 480);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference line walk in plain integers; the visible subset is the expected stream.
    function automatic void build_model(int x1, int y1, int x2, int y2);
        int dx, dy, err, e2, x, y, sx, sy;
        qx.delete(); qy.delete(); ql.delete();
        m_x1 = x1; m_y1 = y1; m_x2 = x2; m_y2 = y2;
        dx = iabs(x2 - x1); dy = -iabs(y2 - y1); err = dx + dy;
        sx = (x1 < x2) ? 1 : -1; sy = (y1 < y2) ? 1 : -1;
        x = x1; y = y1;
        for (int n = 0; n < 4096; n++) begin
            if (on_screen(x, y)) begin
                qx.push_back(x); qy.push_back(y); ql.push_back(x == x2 && y == y2);
            end
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        m_start_vis = on_screen(x1, y1);
        m_end_vis   = on_screen(x2, y2);
    endfunction

    task automatic send_cmd(int x1, int y1, int x2, int y2, logic [23:0] c);
        cmd_x1 = 10'(x1); cmd_y1 = 9'(y1); cmd_x2 = 10'(x2); cmd_y2 = 9'(y2);
        cmd_color = c; m_color = c;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_at_send got %b want 1", cmd_ready);
        end
    endtask

    // Drains one line after send_cmd, checking beats, stalls, latency and the done pulse.
    task automatic collect(int rmode, bit abort_last, string nm);
        int k = 0, idx = 0, last_hs = -1, first_v = -1, done_k = -1;
        int budget = 3000 + 8 * qx.size();
        bit stalled = 0, rdy_bad = 0, rdy_done = 0, pv_done = 1;
        logic [9:0] sx; logic [8:0] sy; logic [23:0] sc; logic sl;
        while (k < budget) begin
            @(negedge clk); k++;
            cmd_valid = 1'b0; abort = 1'b0;
            if (done === 1'b1) begin
                done_k = k; rdy_done = cmd_ready; pv_done = pix_valid; break;
            end
            if (cmd_ready !== 1'b0) rdy_bad = 1;
            if (pix_valid === 1'b1) begin
                if (first_v < 0) first_v = k;
                if (stalled) begin
                    checks++;
                    if (pix_x !== sx || pix_y !== sy || pix_color !== sc || pix_last !== sl) begin
                        errors++;
                        $display("FAIL %s stall_hold got (%0d,%0d,%h,%b) want (%0d,%0d,%h,%b)",
                                 nm, pix_x, pix_y, pix_color, pix_last, sx, sy, sc, sl);
                    end
                end
                pix_ready = (rmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
                if (pix_ready) begin
                    checks++;
                    if (idx >= qx.size()) begin
                        errors++; $display("FAIL %s extra_beat got (%0d,%0d) want none", nm, pix_x, pix_y);
                    end else if (pix_x !== 10'(qx[idx]) || pix_y !== 9'(qy[idx]) ||
                                 pix_last !== ql[idx] || pix_color !== m_color) begin
                        errors++;
                        $display("FAIL %s beat%0d got (%0d,%0d,last=%b,%h) want (%0d,%0d,last=%b,%h)",
                                 nm, idx, pix_x, pix_y, pix_last, pix_color, qx[idx], qy[idx], ql[idx], m_color);
                    end
                    idx++; last_hs = k; stalled = 0;
                    if (abort_last && idx == qx.size()) abort = 1'b1;
                end else begin
                    stalled = 1; sx = pix_x; sy = pix_y; sc = pix_color; sl = pix_last;
                    if ($urandom_range(1) == 1) begin
                        cmd_valid = 1'b1; cmd_x1 = 10'($urandom); cmd_y1 = 9'($urandom);
                    end
                end
            end else begin
                stalled = 0; pix_ready = 1'($urandom_range(1));
            end
        end
        checks++;
        if (done_k < 0) begin errors++; $display("FAIL %s done_timeout got none want pulse", nm); end
        checks++;
        if (idx != qx.size()) begin errors++; $display("FAIL %s beat_count got %0d want %0d", nm, idx, qx.size()); end
`ifndef GPU_LINE_CLIP_EN
        checks++;
        if (idx != ((iabs(m_x2 - m_x1) > iabs(m_y2 - m_y1)) ? iabs(m_x2 - m_x1) : iabs(m_y2 - m_y1)) + 1) begin
            errors++; $display("FAIL %s beat_formula got %0d", nm, idx);
        end
`endif
        if (m_end_vis && done_k > 0) begin
            checks++;
            if (done_k != last_hs + 1) begin errors++; $display("FAIL %s done_timing got %0d want %0d", nm, done_k, last_hs + 1); end
        end
        if (m_start_vis && qx.size() > 0) begin
            checks++;
            if (first_v != 2) begin errors++; $display("FAIL %s first_latency got %0d want 2", nm, first_v); end
        end
        checks++;
        if (rdy_bad || rdy_done !== 1'b1 || pv_done !== 1'b0) begin
            errors++; $display("FAIL %s ready_flags got busy_rdy=%b done_rdy=%b done_pv=%b want 0 1 0", nm, rdy_bad, rdy_done, pv_done);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if ({pix_valid, pix_last, busy, done} !== 4'b0 || pix_x !== '0 || pix_y !== '0 || pix_color !== '0) begin
            errors++; $display("FAIL reset_outputs got v%b l%b b%b d%b (%0d,%0d,%h) want zeros",
                               pix_valid, pix_last, busy, done, pix_x, pix_y, pix_color);
        end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        build_model(0, 5, 3, 5);
        send_cmd(0, 5, 3, 5, 24'h123456);
        collect(0, 0, "horiz");
    endtask

    task automatic test_diag_fixed(int rmode, string nm);
        build_model(2, 4, 0, 0);
        qx = '{2, 1, 1, 0, 0};
        qy = '{4, 3, 2, 1, 0};
        ql = '{0, 0, 0, 0, 1};
        send_cmd(2, 4, 0, 0, 24'hA5C3F0);
        collect(rmode, 0, nm);
    endtask

    task automatic test_single_back_to_back();
        build_model(7, 7, 7, 7);
        send_cmd(7, 7, 7, 7, 24'h00FF00);
        collect(0, 0, "single");
        build_model(1, 1, 4, 2);
        send_cmd(1, 1, 4, 2, 24'h0F0F0F);
        collect(0, 0, "b2b");
    endtask

    task automatic test_abort_reset();
        int nv = 0;
        bit saw_done = 0;
        send_cmd(0, 0, 9, 3, 24'hDEAD01);
        pix_ready = 1'b1;
        for (int k = 0; k < 40 && nv < 2; k++) begin
            @(negedge clk); cmd_valid = 1'b0;
            if (pix_valid === 1'b1) nv++;
            if (nv == 2) abort = 1'b1;
        end
        @(negedge clk); abort = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle got v%b b%b r%b want 0 0 1", pix_valid, busy, cmd_ready);
        end
        for (int k = 0; k < 4; k++) begin
            if (done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done got pulse want none"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL abort_in_idle got b%b r%b d%b want 0 1 0", busy, cmd_ready, done);
        end
        send_cmd(0, 0, 9, 3, 24'hBEEF02);
        nv = 0;
        for (int k = 0; k < 40 && nv < 3; k++) begin
            @(negedge clk); cmd_valid = 1'b0;
            if (pix_valid === 1'b1) nv++;
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_last, busy, done} !== 4'b0 || pix_x !== '0 || pix_y !== '0 ||
            pix_color !== '0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midline_reset got v%b l%b b%b d%b r%b (%0d,%0d,%h) want reset values",
                               pix_valid, pix_last, busy, done, cmd_ready, pix_x, pix_y, pix_color);
        end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_reset got r%b b%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_abort_with_last();
        build_model(3, 3, 6, 1);
        send_cmd(3, 3, 6, 1, 24'h777777);
        collect(0, 1, "abort_last");
    endtask

    task automatic test_clip_edge();
        build_model(637, 0, 642, 0);
        send_cmd(637, 0, 642, 0, 24'h010203);
        collect(0, 0, "edge");
    endtask

    task automatic test_random();
        int x1, y1, x2, y2;
        for (int i = 0; i < 12; i++) begin
            x1 = $urandom_range(700); y1 = $urandom_range(500);
            x2 = (i % 3 == 0) ? x1 + $urandom_range(6) : $urandom_range(700);
            y2 = (i % 3 == 1) ? $urandom_range(20) : $urandom_range(500);
            if (x2 > 1023) x2 = 1023;
            build_model(x1, y1, x2, y2);
            send_cmd(x1, y1, x2, y2, 24'($urandom));
            collect(i % 2, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_diag_fixed(0, "diag");
        test_diag_fixed(1, "diag_stall");
        test_single_back_to_back();
        test_abort_reset();
        test_abort_with_last();
        test_clip_edge();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
